// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcodes, control enums, the E-stage control bundle
// and the ALU-operation helper used by the decode stage.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef struct packed {
        logic        valid;
        logic        reg_wr;
        logic        mem_wr;
        logic        jump;
        logic        branch;
        logic        jalr;
        logic        alu_src;
        logic        pc_src_a;
        result_src_e result_src;
        alu_ctrl_e   alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // funct7[5] selects sub only for register-register ops; for shifts it picks sra.
    function automatic alu_ctrl_e alu_op(input logic [2:0] funct3, input logic funct7b5,
                                         input logic is_reg);
        alu_ctrl_e op;
        case (funct3)
            3'b000:  op = (is_reg && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_regfile_p.sv
// NREGS x XLEN register file, two combinational read ports, one write port, x0 reads 0.
// WB_BYPASS_EN: posedge write plus same-cycle bypass; otherwise negedge write, no bypass.
module rv_regfile_p #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [XLEN-1:0]          rd1,
    output logic [XLEN-1:0]          rd2,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [XLEN-1:0]          wd
);
    localparam int RW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [RW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];

`ifdef WB_BYPASS_EN
    always_ff @(posedge clk) begin
        if (we && wa != '0) regs[wa] <= wd;
    end
`else
    always_ff @(negedge clk) begin
        if (we && wa != '0) regs[wa] <= wd;
    end
`endif

    assign raddr[0] = ra1;
    assign raddr[1] = ra2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef WB_BYPASS_EN
            assign rdata[gi] = (raddr[gi] == '0) ? '0 :
                               (we && wa == raddr[gi]) ? wd : regs[raddr[gi]];
`else
            assign rdata[gi] = (raddr[gi] == '0) ? '0 : regs[raddr[gi]];
`endif
        end
    endgenerate

    assign rd1 = rdata[0];
    assign rd2 = rdata[1];

endmodule

// File: rtl/decode_stage_p.sv
// RV32I decode stage plus ID/EX register with load-use detection, stall and flush.
// Register file write timing/bypass selected by WB_BYPASS_EN (see rv_regfile_p).
module decode_stage_p
    import core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              instrD,
    input  logic                     validD,
    input  logic [XLEN-1:0]          PCD,
    input  logic [XLEN-1:0]          PCp4D,
    input  logic                     stallD,
    input  logic                     flushE,
    input  logic                     reg_wrW,
    input  logic [$clog2(NREGS)-1:0] rdW,
    input  logic [XLEN-1:0]          resultW,
    output logic                     hazard_stall,
    output logic [$clog2(NREGS)-1:0] rs1D,
    output logic [$clog2(NREGS)-1:0] rs2D,
    output logic                     validE,
    output logic                     reg_wrE,
    output logic                     mem_wrE,
    output logic                     jumpE,
    output logic                     branchE,
    output logic                     jalrE,
    output logic                     ALU_srcE,
    output logic                     pc_srcAE,
    output logic [1:0]               result_srcE,
    output logic [ALU_CTRL_W-1:0]    ALU_ctrlE,
    output logic [$clog2(NREGS)-1:0] rs1E,
    output logic [$clog2(NREGS)-1:0] rs2E,
    output logic [$clog2(NREGS)-1:0] rdE,
    output logic [XLEN-1:0]          rd1E,
    output logic [XLEN-1:0]          rd2E,
    output logic [XLEN-1:0]          PCE,
    output logic [XLEN-1:0]          imm_extE,
    output logic [XLEN-1:0]          PCp4E
);
    localparam int RW = $clog2(NREGS);

    logic [6:0]      opcode;
    ctrl_t           ctrl_next;
    imm_src_e        imm_src;
    logic            has_imm, uses_rs1, uses_rs2;
    logic [31:0]     imm_raw;
    logic [XLEN-1:0] imm_next, rd1_next, rd2_next;
    logic [RW-1:0]   rd_next;

    ctrl_t           ctrl_reg;
    logic [RW-1:0]   rs1_reg, rs2_reg, rd_reg;
    logic [XLEN-1:0] rd1_reg, rd2_reg, pc_reg, imm_reg, pcp4_reg;

    assign opcode  = instrD[6:0];
    // lui reads x0 so the ALU computes 0 + imm with no extra operand mux.
    assign rs1D    = (opcode == OP_LUI) ? '0 : instrD[15 +: RW];
    assign rs2D    = instrD[20 +: RW];
    assign rd_next = instrD[7 +: RW];

    always_comb begin
        ctrl_next          = CTRL_BUBBLE;
        ctrl_next.valid    = 1'b1;
        ctrl_next.alu_ctrl = ALU_ADD;
        imm_src            = IMM_I;
        has_imm            = 1'b0;
        uses_rs1           = 1'b0;
        uses_rs2           = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_next.reg_wr   = 1'b1;
                ctrl_next.alu_ctrl = alu_op(instrD[14:12], instrD[30], 1'b1);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                ctrl_next.reg_wr   = 1'b1;
                ctrl_next.alu_src  = 1'b1;
                ctrl_next.alu_ctrl = alu_op(instrD[14:12], instrD[30], 1'b0);
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_LOAD: begin
                ctrl_next.reg_wr     = 1'b1;
                ctrl_next.alu_src    = 1'b1;
                ctrl_next.result_src = RES_MEM;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                ctrl_next.mem_wr  = 1'b1;
                ctrl_next.alu_src = 1'b1;
                imm_src  = IMM_S;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_next.branch   = 1'b1;
                ctrl_next.alu_ctrl = ALU_SUB;
                imm_src  = IMM_B;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                ctrl_next.reg_wr     = 1'b1;
                ctrl_next.jump       = 1'b1;
                ctrl_next.result_src = RES_PC4;
                imm_src = IMM_J;
                has_imm = 1'b1;
            end
            OP_JALR: begin
                ctrl_next.reg_wr     = 1'b1;
                ctrl_next.jump       = 1'b1;
                ctrl_next.jalr       = 1'b1;
                ctrl_next.alu_src    = 1'b1;
                ctrl_next.result_src = RES_PC4;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_LUI: begin
                ctrl_next.reg_wr  = 1'b1;
                ctrl_next.alu_src = 1'b1;
                imm_src = IMM_U;
                has_imm = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_next.reg_wr   = 1'b1;
                ctrl_next.alu_src  = 1'b1;
                ctrl_next.pc_src_a = 1'b1;
                imm_src = IMM_U;
                has_imm = 1'b1;
            end
            default: ;
        endcase
        if (!validD) ctrl_next = CTRL_BUBBLE;
    end

    always_comb begin
        imm_raw = '0;
        case (imm_src)
            IMM_I: imm_raw = {{20{instrD[31]}}, instrD[31:20]};
            IMM_S: imm_raw = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            IMM_B: imm_raw = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25],
                              instrD[11:8], 1'b0};
            IMM_J: imm_raw = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20],
                              instrD[30:21], 1'b0};
            IMM_U: imm_raw = {instrD[31:12], 12'b0};
            default: imm_raw = '0;
        endcase
    end

    assign imm_next = has_imm ? XLEN'($signed(imm_raw)) : '0;

    rv_regfile_p #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk (clk),
        .ra1 (rs1D),
        .ra2 (rs2D),
        .rd1 (rd1_next),
        .rd2 (rd2_next),
        .we  (reg_wrW),
        .wa  (rdW),
        .wd  (resultW)
    );

    assign hazard_stall = !rst && ctrl_reg.valid && (ctrl_reg.result_src == RES_MEM) &&
                          (rd_reg != '0) && validD &&
                          ((rd_reg == rs1D && uses_rs1) || (rd_reg == rs2D && uses_rs2));

    // Reset, flush and load-use all produce the same all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || flushE || hazard_stall) begin
            ctrl_reg <= CTRL_BUBBLE;
            rs1_reg  <= '0;
            rs2_reg  <= '0;
            rd_reg   <= '0;
            rd1_reg  <= '0;
            rd2_reg  <= '0;
            pc_reg   <= '0;
            imm_reg  <= '0;
            pcp4_reg <= '0;
        end else if (!stallD) begin
            ctrl_reg <= ctrl_next;
            rs1_reg  <= rs1D;
            rs2_reg  <= rs2D;
            rd_reg   <= rd_next;
            rd1_reg  <= rd1_next;
            rd2_reg  <= rd2_next;
            pc_reg   <= PCD;
            imm_reg  <= imm_next;
            pcp4_reg <= PCp4D;
        end
    end

    assign validE      = ctrl_reg.valid;
    assign reg_wrE     = ctrl_reg.reg_wr;
    assign mem_wrE     = ctrl_reg.mem_wr;
    assign jumpE       = ctrl_reg.jump;
    assign branchE     = ctrl_reg.branch;
    assign jalrE       = ctrl_reg.jalr;
    assign ALU_srcE    = ctrl_reg.alu_src;
    assign pc_srcAE    = ctrl_reg.pc_src_a;
    assign result_srcE = ctrl_reg.result_src;
    assign ALU_ctrlE   = ALU_CTRL_W'(ctrl_reg.alu_ctrl);
    assign rs1E        = rs1_reg;
    assign rs2E        = rs2_reg;
    assign rdE         = rd_reg;
    assign rd1E        = rd1_reg;
    assign rd2E        = rd2_reg;
    assign PCE         = pc_reg;
    assign imm_extE    = imm_reg;
    assign PCp4E       = pcp4_reg;

endmodule
